// File: rtl/btn_press_classifier.sv
// Pushbutton front end: 2-flop synchronizer, counter debounce, and a
// short/long press classifier with registered one-cycle strobes and a hold level.
module btn_press_classifier #(
    parameter int T    = 4,
    parameter int LONG = 16,
    parameter int CW   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic hold
);

    localparam int DW = $clog2(T);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DOWN = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    localparam logic [DW-1:0] DCNT_MAX = DW'(T - 1);
    localparam logic [CW-1:0] HCNT_MAX = CW'(LONG - 1);

    logic          s0;
    logic          s1;
    logic [DW-1:0] dcnt;
    logic [CW-1:0] hcnt;
    logic [1:0]    state;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= btn;
            s1 <= s0;
        end
    end

    // Level only moves after T consecutive disagreeing samples of s1.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt    <= '0;
            pressed <= 1'b0;
        end else if (s1 == pressed) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_MAX) begin
            pressed <= s1;
            dcnt    <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hcnt        <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            hold        <= 1'b0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= DOWN;
                        hcnt  <= '0;
                    end
                end
                DOWN: begin
                    // Release wins over reaching the threshold on the same edge.
                    if (!pressed) begin
                        state       <= IDLE;
                        short_pulse <= 1'b1;
                    end else if (hcnt == HCNT_MAX) begin
                        state      <= HELD;
                        long_pulse <= 1'b1;
                        hold       <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= IDLE;
                        hold  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Randomized bench for btn_press_classifier: directed press scenarios plus random
// bounce/hold/reset traffic, checked each cycle against a timestamp-based model.
module tb_btn_press_classifier;

    localparam int T    = 4;
    localparam int LONG = 16;
    localparam int CW   = 8;

    logic clk;
    logic reset;
    logic btn;
    logic pressed;
    logic short_pulse;
    logic long_pulse;
    logic hold;

    int n_checks = 0;
    int n_fail   = 0;

    btn_press_classifier #(
        .T   (T),
        .LONG(LONG),
        .CW  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .pressed    (pressed),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse),
        .hold       (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sampled-button pipeline, run-length debounce, and a
    // press tracker keyed on the cycle number at which the debounced level rose.
    logic m_s0, m_s1, m_p;
    int   m_run;
    bit   m_trk, m_ldone;
    int   m_rise;
    int   m_cyc = 0;
    logic e_short, e_long, e_hold;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic step(input logic b, input logic r);
        btn   = b;
        reset = r;
        @(posedge clk);
        m_cyc++;
        if (r) begin
            m_s0 = 1'b0; m_s1 = 1'b0; m_p = 1'b0; m_run = 0;
            m_trk = 1'b0; m_ldone = 1'b0;
            e_short = 1'b0; e_long = 1'b0; e_hold = 1'b0;
        end else begin
            e_short = 1'b0;
            e_long  = 1'b0;
            if (m_trk && !m_p) begin
                e_short = !m_ldone;
                m_trk   = 1'b0;
                m_ldone = 1'b0;
            end else if (m_trk && !m_ldone && (m_cyc - m_rise == LONG + 1)) begin
                e_long  = 1'b1;
                m_ldone = 1'b1;
            end else if (!m_trk && m_p) begin
                m_trk   = 1'b1;
                m_ldone = 1'b0;
                m_rise  = m_cyc - 1;
            end
            e_hold = m_trk && m_ldone;
            if (m_s1 != m_p) begin
                m_run++;
                if (m_run == T) begin
                    m_p   = m_s1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s1 = m_s0;
            m_s0 = b;
        end
        #1;
        check_bit("pressed", pressed, m_p);
        check_bit("short_pulse", short_pulse, e_short);
        check_bit("long_pulse", long_pulse, e_long);
        check_bit("hold", hold, e_hold);
        check_bit("short_and_long", short_pulse & long_pulse, 1'b0);
    endtask

    initial begin
        btn   = 1'b0;
        reset = 1'b1;
        m_s0 = 1'b0; m_s1 = 1'b0; m_p = 1'b0; m_run = 0;
        m_trk = 1'b0; m_ldone = 1'b0; m_rise = 0;
        e_short = 1'b0; e_long = 1'b0; e_hold = 1'b0;

        repeat (3) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);

        // too-short blip, short press, long press
        repeat (3)  step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);

        // bounce then steady hold
        for (int i = 0; i < 20; i++) step(~i[0], 1'b0);
        repeat (30) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);

        // release lands exactly on the threshold edge, then one cycle past it
        repeat (16) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        repeat (17) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);

        // reset mid-press with button held
        repeat (8)  step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                len = int'($urandom_range(1, 8));
                for (int j = 0; j < len; j++) step(1'($urandom), 1'b0);
            end else if (kind < 6) begin
                len = int'($urandom_range(1, 40));
                repeat (len) step(1'b1, 1'b0);
            end else if (kind < 9) begin
                len = int'($urandom_range(1, 20));
                repeat (len) step(1'b0, 1'b0);
            end else begin
                step(1'($urandom), 1'b1);
            end
        end
        repeat (30) step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
